// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: bypass resolution, interlock and a single
// registered slot. Optional stall counter enabled by ALU_OPSTAGE_STALL_CNT_EN.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTL_W = 8,
  parameter int unsigned REG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_a_src,
  input  logic [1:0]       in_b_src,
  input  logic [CTL_W-1:0] in_ac,
  input  logic [REG_W-1:0] in_dst,
  input  logic [WIDTH-1:0] ex_res,
  input  logic             ex_res_vld,
  input  logic [WIDTH-1:0] mem_res,
  input  logic             mem_res_vld,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CTL_W-1:0] out_ac,
  output logic [REG_W-1:0] out_dst,
  output logic             out_ill
`ifdef ALU_OPSTAGE_STALL_CNT_EN
  ,
  input  logic             stall_cnt_clr,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_EX   = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_ZERO = 2'd3
  } src_e;

  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic             hz;
  logic             capture;
  logic             op_ill;

  function automatic logic [WIDTH-1:0] resolve(
    input logic [1:0]       src,
    input logic [WIDTH-1:0] reg_val,
    input logic [WIDTH-1:0] ex_val,
    input logic [WIDTH-1:0] mem_val
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (src_e'(src))
      SRC_REG:  r = reg_val;
      SRC_EX:   r = ex_val;
      SRC_MEM:  r = mem_val;
      SRC_ZERO: r = '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic pending(
    input logic [1:0] src,
    input logic       ex_v,
    input logic       mem_v
  );
    return ((src_e'(src) == SRC_EX) && !ex_v) || ((src_e'(src) == SRC_MEM) && !mem_v);
  endfunction

  always_comb begin
    res_a   = resolve(in_a_src, in_a, ex_res, mem_res);
    res_b   = resolve(in_b_src, in_b, ex_res, mem_res);
    hz      = pending(in_a_src, ex_res_vld, mem_res_vld) |
              pending(in_b_src, ex_res_vld, mem_res_vld);
    op_ill  = (in_ac[7:5] == 3'd4);
    // hz only gates acceptance; the held entry still drains on out_ready
    in_ready = (!out_valid || out_ready) && !hz;
    capture  = in_valid && in_ready && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_ac    <= '0;
      out_dst   <= '0;
      out_ill   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_a     <= res_a;
      out_b     <= res_b;
      out_ac    <= in_ac;
      out_dst   <= in_dst;
      out_ill   <= op_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_OPSTAGE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (in_valid && hz && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios followed by random traffic,
// all checked against a table-driven reference of the stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_a_src, in_b_src;
  logic [7:0]  in_ac;
  logic [3:0]  in_dst;
  logic [31:0] ex_res, mem_res;
  logic        ex_res_vld, mem_res_vld;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [7:0]  out_ac;
  logic [3:0]  out_dst;
  logic        out_ill;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
  logic        stall_cnt_clr;
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // reference state
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [7:0]  m_ac;
  logic [3:0]  m_dst;
  logic        m_ill;
  logic        m_known;
  int          m_cnt;

  logic [31:0] saved_a, saved_b;
  logic [7:0]  saved_ac;

  alu_operand_stage #(.WIDTH(32), .CTL_W(8), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_a_src(in_a_src), .in_b_src(in_b_src),
    .in_ac(in_ac), .in_dst(in_dst),
    .ex_res(ex_res), .ex_res_vld(ex_res_vld),
    .mem_res(mem_res), .mem_res_vld(mem_res_vld),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ac(out_ac), .out_dst(out_dst),
    .out_ill(out_ill)
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    , .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_ac = '0; m_dst = '0; m_ill = 1'b0;
    m_known = 1'b1; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, out_valid, m_valid);
    if (m_known) begin
      chk({tag, ".a"},   out_a,   m_a);
      chk({tag, ".b"},   out_b,   m_b);
      chk({tag, ".ac"},  out_ac,  m_ac);
      chk({tag, ".dst"}, out_dst, m_dst);
      chk({tag, ".ill"}, out_ill, m_ill);
    end
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    chk({tag, ".cnt"}, stall_cnt, m_cnt);
`endif
  endtask

  // One clock: inputs already driven; check in_ready, advance model, check outputs.
  task automatic cycle(input string tag);
    logic [31:0] a_tab [4];
    logic [31:0] b_tab [4];
    logic        avail [4];
    logic        hz, rdy, clr;
    #1;
    a_tab = '{in_a, ex_res, mem_res, 32'h0};
    b_tab = '{in_b, ex_res, mem_res, 32'h0};
    avail = '{1'b1, ex_res_vld, mem_res_vld, 1'b1};
    hz  = !avail[in_a_src] || !avail[in_b_src];
    rdy = (!m_valid || out_ready) && !hz;
    chk({tag, ".in_ready"}, in_ready, rdy);
    clr = 1'b0;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    clr = stall_cnt_clr;
`endif
    if (clr) m_cnt = 0;
    else if (in_valid && hz && !flush && m_cnt < 65535) m_cnt = m_cnt + 1;
    if (flush) begin
      m_valid = 1'b0;
      m_known = 1'b0;
    end else if (in_valid && rdy) begin
      m_valid = 1'b1;
      m_a = a_tab[in_a_src];
      m_b = b_tab[in_b_src];
      m_ac = in_ac;
      m_dst = in_dst;
      m_ill = (((in_ac >> 5) & 8'd7) == 8'd4);
      m_known = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] asrc, input logic [1:0] bsrc,
                        input logic [7:0] ac, input logic [3:0] dst);
    in_valid = 1'b1; in_a = a; in_b = b; in_a_src = asrc; in_b_src = bsrc;
    in_ac = ac; in_dst = dst;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_a_src = '0; in_b_src = '0;
    in_ac = '0; in_dst = '0; ex_res = '0; ex_res_vld = 1'b1; mem_res = '0;
    mem_res_vld = 1'b1; flush = 1'b0; out_ready = 1'b1;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    model_reset();
    @(posedge clk); #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-operation, no clock edge in between
    set_op(32'h12345678, 32'h1, 2'd0, 2'd0, 8'h61, 4'd1);
    out_ready = 1'b0;
    cycle("cap_pre_rst");
    chk("cap_pre_rst.a", out_a, 32'h12345678);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.valid", out_valid, 1'b0);
    chk("async_rst.a", out_a, 32'h0);
    #2;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle("post_rst");

    // Back-to-back captures
    for (int i = 0; i < 3; i++) begin
      set_op(32'h5, 32'h3, 2'd0, 2'd0, 8'h61, 4'(i + 2));
      cycle("b2b");
      chk("b2b.valid_hi", out_valid, 1'b1);
      chk("b2b.dst", out_dst, 4'(i + 2));
    end

    // Backpressure: held entry stays while a new op waits
    out_ready = 1'b0;
    set_op(32'hCAFE_0001, 32'hCAFE_0002, 2'd0, 2'd0, 8'h21, 4'd9);
    saved_a = out_a; saved_b = out_b; saved_ac = out_ac;
    for (int i = 0; i < 4; i++) begin
      cycle("hold");
      chk("hold.a", out_a, saved_a);
      chk("hold.b", out_b, saved_b);
      chk("hold.ac", out_ac, saved_ac);
    end
    out_ready = 1'b1;
    cycle("hold_release");
    chk("hold_release.a", out_a, 32'hCAFE_0001);

    // EX bypass interlock
    in_valid = 1'b0;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    stall_cnt_clr = 1'b1;
`endif
    cycle("drain_clr");
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    set_op(32'h0, 32'h7, 2'd1, 2'd0, 8'h01, 4'd3);
    ex_res = 32'h0BAD_0BAD; ex_res_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ex_stall.in_ready", in_ready, 1'b0);
      cycle("ex_stall");
    end
    ex_res = 32'hDEAD_BEEF; ex_res_vld = 1'b1;
    cycle("ex_go");
    chk("ex_go.a", out_a, 32'hDEAD_BEEF);
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    chk("ex_go.stall_cnt", stall_cnt, 16'd2);
`endif

    // Flush with a simultaneous incoming op
    out_ready = 1'b0;
    set_op(32'h1111_2222, 32'h0, 2'd0, 2'd0, 8'h40, 4'd5);
    cycle("flush_pre");
    set_op(32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'd0, 2'd0, 8'h60, 4'd6);
    flush = 1'b1;
    cycle("flush");
    chk("flush.valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle("post_flush");
      chk("post_flush.valid", out_valid, 1'b0);
    end

    // Zero source, reserved op, MEM bypass
    set_op(32'h1234, 32'h5678, 2'd2, 2'd3, 8'h80, 4'd7);
    mem_res = 32'hFFFF_0000; mem_res_vld = 1'b1;
    cycle("srcs");
    chk("srcs.b_zero", out_b, 32'h0);
    chk("srcs.ill", out_ill, 1'b1);
    chk("srcs.a_mem", out_a, 32'hFFFF_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_a        = $urandom;
      in_b        = $urandom;
      in_a_src    = 2'($urandom_range(0, 3));
      in_b_src    = 2'($urandom_range(0, 3));
      in_ac       = 8'($urandom);
      in_dst      = 4'($urandom);
      ex_res      = $urandom;
      mem_res     = $urandom;
      ex_res_vld  = ($urandom_range(0, 2) != 0);
      mem_res_vld = ($urandom_range(0, 2) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 9) == 0);
`ifdef ALU_OPSTAGE_STALL_CNT_EN
      stall_cnt_clr = ($urandom_range(0, 49) == 0);
`endif
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
